vec_seq_core: RTL
=================

// Module: vec_seq_core
// PURPOSE
//  Parametrised multi-cycle vector core: NREG registers of VLEN bits, internal MEM_DEPTH x VLEN data memory,
//  lane-sliced ALU (ADD/MUL) processing LANES elements per cycle. Accepts one instruction per valid/ready
//  handshake. Replaces the single-cycle fixed 512-bit/4-reg core. Adds reset, backpressure, preload and debug access.
// PARAMETERS
//  VLEN       512  vector register / memory word width (bits)
//  ELEM_W     32   element width; NELEM = VLEN/ELEM_W
//  LANES      4    elements per ALU beat; NBEATS = NELEM/LANES (VLEN % (ELEM_W*LANES) must be 0)
//  NREG       4    register count, power of 2, >= 4
//  MEM_DEPTH  32   memory words, power of 2; IW = 2 + clog2(NREG) + clog2(MEM_DEPTH) (9 at defaults)
// PORTS
//  clk            in   1         clock, all state on rising edge
//  rst            in   1         synchronous active-high reset
//  instr          in   IW        {opc[1:0], rs, addr}; opc 00 LOAD, 01 STORE, 10 ADD, 11 MUL
//  instr_valid    in   1         instr present
//  instr_ready    out  1         core can accept (high only in IDLE)
//  busy           out  1         ~instr_ready
//  done           out  1         one-cycle pulse: previous instruction retired
//  init_we        in   1         memory preload write (honoured only in IDLE with no handshake that cycle)
//  init_addr      in   clog2(MEM_DEPTH)  preload address
//  init_data      in   VLEN      preload data
//  dbg_sel        in   clog2(NREG)  debug register select
//  dbg_data       out  VLEN      combinational read of reg[dbg_sel]
// BEHAVIOUR
//  - Reset: state IDLE, all registers 0, instr_ready=1, done=0, busy=0, beat counter 0. Memory not cleared.
//    rst mid-instruction aborts: no further reg/mem writes, no done pulse. rst wins over handshake and init_we.
//  - FSM IDLE/LD/ST/EXEC. Handshake at edge E0 (instr_valid & instr_ready) captures opc/rs/addr.
//  - LOAD: mem read issued at E0 (sync read); state LD; at E1 reg[rs] <= mem[addr]; IDLE; done in cycle after E1.
//  - STORE: state ST; at E1 mem[addr] <= reg[rs] (value at E1); IDLE; done after E1.
//  - ADD/MUL: always read R0,R1, write R2 (low) and R3 (high); rs/addr ignored. State EXEC, beat=0.
//    Beat b at edge E0+1+b writes elements b*LANES..b*LANES+LANES-1 (element i = bits [i*ELEM_W +: ELEM_W]).
//    After edge E0+NBEATS: IDLE, done pulses. Busy NBEATS cycles (4 at defaults).
//  - ADD: R2.e = (R0.e+R1.e) mod 2^ELEM_W; R3.e = carry-out, zero-extended.
//  - MUL: unsigned 2*ELEM_W product; low half -> R2.e, high half -> R3.e.
//  - instr_ready=1 in the cycle done is high: back-to-back issue allowed, no bubble.
//  - init_we ignored when busy or when a handshake occurs in the same cycle.
//  - Beat counter wraps to 0 on EXEC exit; never exceeds NBEATS-1.
// CONFIGURATION
//  VEC_PERF_CNT_EN defined: adds outputs perf_instr[31:0] (retired count, +1 per done) and perf_busy[31:0]
//   (+1 per cycle busy=1); both clear on rst, wrap at 2^32. Undefined: ports and counters absent,
//   all other behaviour identical.
// STRUCTURE
//  - vec_pkg: opcode constants (OPC_LOAD/STORE/ADD/MUL), FSM state encodings, clog2 helper.
//  - Sub-module vec_lane_alu: LANES x ELEM_W slice, inputs op + two slices, outputs lo/hi slices; purely
//    combinational, instantiated once and muxed by beat index. Register file and memory inline.
// TESTING
//  1 rst mid-ADD (after beat 1): R2 keeps beats-0..1 values only if written before rst -> all regs 0 after
//    rst, no done, instr_ready=1 next cycle.
//  2 preload mem[3]=elements 1..16; LOAD rs=0 addr=3 -> done 2 cycles after accept, dbg_data(R0) == mem[3].
//  3 R0 all 0xFFFFFFFF, R1 all 0x00000001, ADD -> done after 4 busy cycles; R2 all 0, R3 all 0x00000001.
//  4 R0 all 0xFFFFFFFF, R1 all 0x00000002, MUL -> R2 all 0xFFFFFFFE, R3 all 0x00000001.
//  5 STORE rs=2 addr=31 then LOAD rs=1 addr=31 back-to-back (valid held) -> R1 == R2, no idle cycle between.
//  6 init_we with addr=5 while busy in MUL -> mem[5] unchanged (verify by LOAD); with VEC_PERF_CNT_EN
//    perf_instr=2, perf_busy=5 after one MUL+one LOAD.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared opcode constants, FSM state encoding and a width helper for the vector core.
package vec_pkg;

  localparam logic [1:0] OPC_LOAD  = 2'b00;
  localparam logic [1:0] OPC_STORE = 2'b01;
  localparam logic [1:0] OPC_ADD   = 2'b10;
  localparam logic [1:0] OPC_MUL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LD   = 2'b01,
    ST_ST   = 2'b10,
    ST_EXEC = 2'b11
  } vec_state_e;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int vec_clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational LANES x ELEM_W slice ALU: ADD gives sum/carry, MUL gives low/high product halves.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int ELEM_W = 32,
  parameter int LANES  = 4
) (
  input  logic [1:0]              op_i,
  input  logic [LANES*ELEM_W-1:0] a_i,
  input  logic [LANES*ELEM_W-1:0] b_i,
  output logic [LANES*ELEM_W-1:0] lo_o,
  output logic [LANES*ELEM_W-1:0] hi_o
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ELEM_W-1:0]   a_e;
    logic [ELEM_W-1:0]   b_e;
    logic [ELEM_W:0]     sum;
    logic [2*ELEM_W-1:0] prod;

    assign a_e  = a_i[gi*ELEM_W +: ELEM_W];
    assign b_e  = b_i[gi*ELEM_W +: ELEM_W];
    assign sum  = {1'b0, a_e} + {1'b0, b_e};
    assign prod = {{ELEM_W{1'b0}}, a_e} * {{ELEM_W{1'b0}}, b_e};

    // Carry-out of the add is zero-extended into the high element.
    assign lo_o[gi*ELEM_W +: ELEM_W] = (op_i == OPC_MUL) ? prod[ELEM_W-1:0] : sum[ELEM_W-1:0];
    assign hi_o[gi*ELEM_W +: ELEM_W] = (op_i == OPC_MUL) ? prod[2*ELEM_W-1:ELEM_W]
                                                         : {{(ELEM_W-1){1'b0}}, sum[ELEM_W]};
  end

endmodule

// File: rtl/vec_seq_core.sv
// Multi-cycle vector core: register file, sync-read data memory, beat-sliced ALU, preload and debug read.
// Optional VEC_PERF_CNT_EN adds retired-instruction and busy-cycle counters.
module vec_seq_core
  import vec_pkg::*;
#(
  parameter  int VLEN      = 512,
  parameter  int ELEM_W    = 32,
  parameter  int LANES     = 4,
  parameter  int NREG      = 4,
  parameter  int MEM_DEPTH = 32,
  localparam int AW        = vec_clog2(MEM_DEPTH),
  localparam int RW        = vec_clog2(NREG),
  localparam int IW        = 2 + RW + AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic            busy,
  output logic            done,
  input  logic            init_we,
  input  logic [AW-1:0]   init_addr,
  input  logic [VLEN-1:0] init_data,
  input  logic [RW-1:0]   dbg_sel,
  output logic [VLEN-1:0] dbg_data
`ifdef VEC_PERF_CNT_EN
  ,
  output logic [31:0]     perf_instr,
  output logic [31:0]     perf_busy
`endif
);

  localparam int NELEM   = VLEN / ELEM_W;
  localparam int SLICE_W = LANES * ELEM_W;
  localparam int NBEATS  = NELEM / LANES;
  localparam int BW      = (NBEATS > 1) ? vec_clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  vec_state_e state_q, state_d;

  logic [VLEN-1:0] reg_q [NREG];
  logic [VLEN-1:0] mem   [MEM_DEPTH];
  logic [VLEN-1:0] rd_data_q;

  logic [BW-1:0]   beat_q, beat_d;
  logic [RW-1:0]   rs_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      opc_q;
  logic            done_q;

  logic [1:0]      instr_opc;
  logic [RW-1:0]   instr_rs;
  logic [AW-1:0]   instr_addr;
  logic            handshake;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [VLEN-1:0] mem_wdata;

  int unsigned     slice_lo;
  logic [SLICE_W-1:0] alu_a, alu_b, alu_lo, alu_hi;

  assign instr_opc  = instr[IW-1 -: 2];
  assign instr_rs   = instr[AW +: RW];
  assign instr_addr = instr[AW-1:0];
  assign handshake  = instr_valid & instr_ready;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          unique case (instr_opc)
            OPC_LOAD:  state_d = ST_LD;
            OPC_STORE: state_d = ST_ST;
            default:   state_d = ST_EXEC;
          endcase
        end
      end
      ST_LD:   state_d = ST_IDLE;
      ST_ST:   state_d = ST_IDLE;
      ST_EXEC: begin
        if (beat_q == LAST_BEAT) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    instr_ready = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    done        = done_q;
  end

  always_comb begin
    beat_d = '0;
    if ((state_q == ST_EXEC) && (beat_q != LAST_BEAT)) begin
      beat_d = beat_q + 1'b1;
    end
  end

  assign slice_lo = int'(beat_q) * SLICE_W;
  assign alu_a    = reg_q[0][slice_lo +: SLICE_W];
  assign alu_b    = reg_q[1][slice_lo +: SLICE_W];

  vec_lane_alu #(
    .ELEM_W (ELEM_W),
    .LANES  (LANES)
  ) u_alu (
    .op_i (opc_q),
    .a_i  (alu_a),
    .b_i  (alu_b),
    .lo_o (alu_lo),
    .hi_o (alu_hi)
  );

  // Register file, captured instruction fields and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        reg_q[i] <= '0;
      end
      beat_q <= '0;
      rs_q   <= '0;
      addr_q <= '0;
      opc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      done_q <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
      if (handshake) begin
        rs_q   <= instr_rs;
        addr_q <= instr_addr;
        opc_q  <= instr_opc;
      end
      if (state_q == ST_LD) begin
        reg_q[rs_q] <= rd_data_q;
      end
      if (state_q == ST_EXEC) begin
        reg_q[2][slice_lo +: SLICE_W] <= alu_lo;
        reg_q[3][slice_lo +: SLICE_W] <= alu_hi;
      end
    end
  end

  // Single write port shared by STORE and preload; preload only lands in an idle cycle without an issue.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_addr;
    mem_wdata = init_data;
    if (!rst) begin
      if (state_q == ST_ST) begin
        mem_we    = 1'b1;
        mem_waddr = addr_q;
        mem_wdata = reg_q[rs_q];
      end else if (init_we && (state_q == ST_IDLE) && !handshake) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (handshake) begin
      rd_data_q <= mem[instr_addr];
    end
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign dbg_data = reg_q[dbg_sel];

`ifdef VEC_PERF_CNT_EN
  logic [31:0] perf_instr_q, perf_busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_instr_q <= '0;
      perf_busy_q  <= '0;
    end else begin
      if (done_q) begin
        perf_instr_q <= perf_instr_q + 32'd1;
      end
      if (busy) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
    end
  end

  assign perf_instr = perf_instr_q;
  assign perf_busy  = perf_busy_q;
`endif

endmodule
